// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Fetch stage with a 64 x 32-bit instruction memory and a three-state
//   IDLE / RUN / HALT controller. The memory is loaded through the prog_*
//   port while IDLE. It is read combinationally at word index pc_out[7:2], so
//   fetch addresses wrap every 256 bytes while pc_out keeps its full 64 bits.
//
// Configuration:
//   FETCH_ALIGN_CHECK_EN - when defined, a taken branch to a target that is
//     not word aligned sets the sticky misalign_err flag, keeps the PC and
//     halts. When undefined, the low two target bits are cleared,
//     misalign_err is tied low and the branch proceeds.
//
// Ports:
//   clk            in   rising-edge clock for all state
//   reset          in   asynchronous active-high reset (memory is retained)
//   start          in   level: IDLE->RUN, HALT->IDLE (ignored in RUN)
//   stall          in   hold PC and state for this cycle (beats branch/halt)
//   branch_taken   in   select branch_target as next PC
//   branch_target  in   [63:0] byte address of next instruction
//   prog_we        in   memory write enable, honoured only in IDLE
//   prog_addr      in   [5:0] word index for writes
//   prog_data      in   [31:0] word to write
//   pc_out         out  [63:0] current PC
//   instruction    out  [31:0] word at current PC
//   opcode         out  [6:0] instruction[6:0] when instr_valid, else 0
//   instr_valid    out  high only in RUN
//   halted         out  high only in HALT
//   misalign_err   out  sticky misaligned-branch flag
//   state_dbg      out  [1:0] raw FSM state (0=IDLE, 1=RUN, 2=HALT)
//
// Handshake: there is no valid/ready pairing here. instr_valid qualifies
// instruction/opcode in the same cycle, and stall is a plain hold request
// that the consumer may raise in any cycle without a response.
// -----------------------------------------------------------------------------
module instruction_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        prog_we,
  input  logic [5:0]  prog_addr,
  input  logic [31:0] prog_data,
  output logic [63:0] pc_out,
  output logic [31:0] instruction,
  output logic [6:0]  opcode,
  output logic        instr_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] HALT_WORD = 32'h0000_0073;

  state_t      state;
  logic [31:0] mem [64];
  logic        is_halt;

  // Combinational read. Only bits [7:2] index the array, so the fetch
  // address wraps every 256 bytes while the PC itself is not truncated.
  assign instruction = mem[pc_out[7:2]];
  assign is_halt     = (instruction == HALT_WORD);
  // With no valid instruction, a zero opcode keeps every decoder control low.
  assign opcode      = instr_valid ? instruction[6:0] : 7'b000_0000;
  assign state_dbg   = state;

  // The memory has no reset, so a program survives a reset of the controller.
  always_ff @(posedge clk) begin
    if (prog_we && (state == ST_IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

`ifndef FETCH_ALIGN_CHECK_EN
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_RUN;
            instr_valid <= 1'b1;
          end
        end

        ST_RUN: begin
          // stall freezes everything: any branch this cycle is dropped and
          // the halt word is not acted on until stall falls.
          if (!stall) begin
            if (is_halt) begin
              // The halt word has been shown for this cycle. The PC stays on it.
              state       <= ST_HALT;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
            end else if (branch_taken) begin
`ifdef FETCH_ALIGN_CHECK_EN
              if (branch_target[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
                state        <= ST_HALT;
                instr_valid  <= 1'b0;
                halted       <= 1'b1;
              end else begin
                pc_out <= branch_target;
              end
`else
              pc_out <= branch_target & ~64'h3;
`endif
            end else begin
              pc_out <= pc_out + 64'd4;
            end
          end
        end

        ST_HALT: begin
          if (start) begin
            state  <= ST_IDLE;
            halted <= 1'b0;
            pc_out <= '0;
          end
        end

        default: begin
          state       <= ST_IDLE;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, single rising-edge clock for all state.
REQ-002 The block SHALL have the port reset, input, 1 bit, asynchronous active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit, level: IDLE->RUN, HALT->IDLE.
REQ-004 The block SHALL have the port stall, input, 1 bit, hold PC and state for this cycle.
REQ-005 The block SHALL have the port branch_taken, input, 1 bit, select branch_target as next PC.
REQ-006 The block SHALL have the port branch_target, input, 64 bits, byte address of next instruction.
REQ-007 The block SHALL have the port prog_we, input, 1 bit, instruction-memory write enable.
REQ-008 The block SHALL have the port prog_addr, input, 6 bits, word index for writes.
REQ-009 The block SHALL have the port prog_data, input, 32 bits, word to write.
REQ-010 The block SHALL have the port pc_out, output, 64 bits, current PC.
REQ-011 The block SHALL have the port instruction, output, 32 bits, word at current PC.
REQ-012 The block SHALL have the port opcode, output, 7 bits, decoder feed.
REQ-013 The block SHALL have the port instr_valid, output, 1 bit, instruction/opcode meaningful.
REQ-014 The block SHALL have the port halted, output, 1 bit, state==HALT.
REQ-015 The block SHALL have the port misalign_err, output, 1 bit, sticky misaligned-target flag.

Function
REQ-016 Instruction memory SHALL be 64 x 32-bit words, read combinationally at index pc_out[7:2]; addresses wrap modulo 256 bytes, pc_out itself is not truncated.
REQ-017 FSM SHALL have states IDLE, RUN and HALT, with IDLE->RUN on start, RUN->HALT on halt condition, and HALT->IDLE on start.
REQ-018 On the HALT->IDLE transition, pc_out SHALL be loaded with 0.
REQ-019 Writes SHALL occur on the clock edge only when prog_we=1 and state==IDLE; prog_we SHALL be ignored in RUN and HALT.
REQ-020 instr_valid SHALL be 1 only in RUN.
REQ-021 opcode SHALL equal instruction[6:0] when instr_valid=1, else 7'b0000000, so the decoder drives all control signals low.
REQ-022 In RUN with stall=0, the next PC SHALL be branch_taken ? branch_target : pc_out+4, using 64-bit wrap-around addition.
REQ-023 stall=1 SHALL hold pc_out and state; stall SHALL win over branch_taken and halt detection, and the branch is dropped.
REQ-024 The halt condition SHALL be instruction==32'h00000073 with stall=0 in RUN.
REQ-025 The halting word SHALL be presented with instr_valid=1 for one cycle; PC SHALL not advance, and the next state SHALL be HALT.
REQ-026 In IDLE and HALT, pc_out SHALL be held except for the HALT->IDLE clear.
REQ-027 start SHALL be ignored in RUN.
REQ-028 If halt and branch_taken coincide, halt SHALL win.

Reset
REQ-029 Assertion of reset SHALL immediately force pc_out=0, state=IDLE, instr_valid=0, opcode=0, halted=0 and misalign_err=0.
REQ-030 Instruction memory contents SHALL be retained across reset.
REQ-031 Reset mid-RUN SHALL discard any pending branch, and the block SHALL refetch from 0 after a new start.

Configuration
REQ-032 Macro FETCH_ALIGN_CHECK_EN SHALL control handling of a taken branch with branch_target[1:0]!=0 in RUN with stall=0.
REQ-033 With FETCH_ALIGN_CHECK_EN defined, such a branch SHALL set misalign_err (sticky until reset), keep PC unchanged, and move the state to HALT.
REQ-034 Without FETCH_ALIGN_CHECK_EN, branch_target[1:0] SHALL be forced to 00, misalign_err SHALL be tied to 0, and no halt SHALL occur.

Verification
REQ-035 Program words 0..2 = 00000033, 00000013, 00000073, then pulse start -> pc_out 0,4,8 with instr_valid=1 on consecutive cycles, then halted=1, instr_valid=0, opcode=0.
REQ-036 In RUN at PC=4, branch_taken=1 with target=0x40 -> next pc_out=0x40, instruction=mem[16].
REQ-037 stall=1 for 3 cycles together with branch_taken=1 -> pc_out unchanged for 3 cycles, no redirect; after release, pc_out advances by +4.
REQ-038 prog_we=1 in RUN to index 0 -> mem[0] unchanged after halt, reset and readback.
REQ-039 Branch target 0x102 -> with FETCH_ALIGN_CHECK_EN: misalign_err=1, halted=1, pc_out unchanged; without it: pc_out=0x100, misalign_err=0.
REQ-040 Reset asserted mid-RUN at PC=0x20 -> immediate pc_out=0, instr_valid=0; memory intact; start resumes from 0.
